// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit.
package muldiv_pkg;

    // RV32M funct3 encodings (OPC_ARI_RTYPE with funct7 = FNC7_MULDIV)
    localparam logic [2:0] FNC_MUL    = 3'b000;
    localparam logic [2:0] FNC_MULH   = 3'b001;
    localparam logic [2:0] FNC_MULHSU = 3'b010;
    localparam logic [2:0] FNC_MULHU  = 3'b011;
    localparam logic [2:0] FNC_DIV    = 3'b100;
    localparam logic [2:0] FNC_DIVU   = 3'b101;
    localparam logic [2:0] FNC_REM    = 3'b110;
    localparam logic [2:0] FNC_REMU   = 3'b111;

    localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

    // Control FSM states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // Which word of the datapath becomes the result
    typedef enum logic [1:0] {
        SEL_LO  = 2'd0,   // product[31:0]
        SEL_HI  = 2'd1,   // product[63:32]
        SEL_QUO = 2'd2,   // quotient
        SEL_REM = 2'd3    // remainder
    } md_sel_e;

    // Decoder helper: instruction belongs to the M extension
    function automatic logic fnc_is_muldiv(input logic [6:0] funct7);
        return funct7 == FNC7_MULDIV;
    endfunction

    function automatic md_sel_e fnc_sel(input logic [2:0] f);
        md_sel_e s;
        case (f)
            FNC_MUL:            s = SEL_LO;
            FNC_DIV, FNC_DIVU:  s = SEL_QUO;
            FNC_REM, FNC_REMU:  s = SEL_REM;
            default:            s = SEL_HI;
        endcase
        return s;
    endfunction

    function automatic logic fnc_a_signed(input logic [2:0] f);
        return (f == FNC_MULH) || (f == FNC_MULHSU) || (f == FNC_DIV) || (f == FNC_REM);
    endfunction

    function automatic logic fnc_b_signed(input logic [2:0] f);
        return (f == FNC_MULH) || (f == FNC_DIV) || (f == FNC_REM);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One combinational iteration of the iterative datapath:
//   multiply - radix-2 shift-add: {hi,lo} is the product/multiplier pair,
//              mcand the multiplicand magnitude.
//   divide   - restoring step: hi is the partial remainder, lo shifts the
//              dividend out and the quotient in, mcand is the divisor magnitude.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] mcand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    // Single step of shift-add or restoring subtract
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        hi_next = hi;
        lo_next = lo;
        sum     = '0;
        shifted = {hi, lo[XLEN-1]};
        fits    = 1'b0;
        diff    = '0;
        if (is_div) begin
            // The remainder stays below the divisor, so the low XLEN bits of
            // the difference are exact whenever the subtraction fits.
            fits    = shifted >= {1'b0, mcand};
            diff    = shifted[XLEN-1:0] - mcand;
            hi_next = fits ? diff : shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], fits};
        end else begin
            sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// accept, iterated for XLEN cycles in muldiv_core, sign-corrected in FIX and
// presented with a valid/ready handshake in DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            Clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Out,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q, state_d;
    md_sel_e          sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic              accept;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_by_zero, div_ovf;
    md_sel_e           sel_in;
    logic              core_is_div;
    logic [XLEN-1:0]   core_hi, core_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   result;

    assign in_ready  = (state_q == MD_IDLE);
    assign busy      = (state_q != MD_IDLE);
    assign out_valid = out_valid_q;
    assign Out       = out_q;

    assign core_is_div = (sel_q == SEL_QUO) || (sel_q == SEL_REM);

    muldiv_core #(.XLEN(XLEN)) u_core (
        .is_div  (core_is_div),
        .hi      (hi_q),
        .lo      (lo_q),
        .mcand   (mcand_q),
        .hi_next (core_hi),
        .lo_next (core_lo)
    );

    // Operand decode on the accept cycle: signs, magnitudes, special cases
    always_comb begin
        sel_in      = fnc_sel(funct);
        a_neg       = fnc_a_signed(funct) & A[XLEN-1];
        b_neg       = fnc_b_signed(funct) & B[XLEN-1];
        a_mag       = a_neg ? -A : A;
        b_mag       = b_neg ? -B : B;
        div_by_zero = funct[2] && (B == '0);
        div_ovf     = ((funct == FNC_DIV) || (funct == FNC_REM)) && (A == MIN_INT) && (B == '1);
        accept      = in_valid && (state_q == MD_IDLE) && !kill;
    end

    // Sign correction and output word selection, used in FIX
    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        case (sel_q)
            SEL_LO:  result = prod_fix[XLEN-1:0];
            SEL_HI:  result = prod_fix[2*XLEN-1:XLEN];
            SEL_QUO: result = neg_q ? -lo_q : lo_q;
            default: result = neg_q ? -hi_q : hi_q;
        endcase
    end

    // Next-state logic for the FSM, counter and datapath registers
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mcand_d     = mcand_q;
        neg_d       = neg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    sel_d = sel_in;
                    cnt_d = '0;
                    if (div_by_zero || div_ovf) begin
                        // Preload the final words so FIX selects them unchanged:
                        // quotient in lo, remainder in hi, no sign correction.
                        hi_d    = div_by_zero ? A : '0;
                        lo_d    = div_by_zero ? '1 : MIN_INT;
                        neg_d   = 1'b0;
                        state_d = MD_FIX;
                    end else begin
                        hi_d    = '0;
                        lo_d    = funct[2] ? a_mag : b_mag;
                        mcand_d = funct[2] ? b_mag : a_mag;
                        neg_d   = (sel_in == SEL_REM) ? a_neg : (a_neg ^ b_neg);
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                hi_d  = core_hi;
                lo_d  = core_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                out_d   = result;
                state_d = MD_DONE;
            end
            default: begin
                // First DONE cycle raises out_valid; the result then waits for out_ready.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = MD_IDLE;
                end
            end
        endcase

        // A flush abandons whatever is in flight and wins over out_ready.
        if (kill && (state_q != MD_IDLE)) begin
            state_d     = MD_IDLE;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MD_IDLE;
            sel_q       <= SEL_LO;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mcand_q     <= '0;
            neg_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mcand_q     <= mcand_d;
            neg_q       <= neg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, backpressure, kill,
// asynchronous reset and randomized operations against an arithmetic model.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT_NORMAL  = 34;
    localparam int LAT_SPECIAL = 2;

    logic            Clock;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Out;
    logic            busy;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(XLEN), .CNT_W(5)) dut (
        .Clock     (Clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .A         (A),
        .B         (B),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .busy      (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          si, sj;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        si = a;
        sj = b;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return si / sj;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return si % sj;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return LAT_SPECIAL;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
        return LAT_NORMAL;
    endfunction

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        funct    = f;
        A        = a;
        B        = b;
        @(negedge Clock);
        in_valid = 1'b0;
        funct    = 3'($urandom);
        A        = $urandom;
        B        = $urandom;
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_result(input string tag, input int lat_exp, input logic [31:0] out_exp);
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge Clock);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_out"}, Out, out_exp);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge Clock);
        out_ready = 1'b0;
        check({tag, "_consumed"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int lat_exp, input logic [31:0] out_exp);
        issue(tag, f, a, b);
        wait_result(tag, lat_exp, out_exp);
        consume(tag);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        logic [31:0] held;
        logic        rose;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        funct     = 3'd0;
        A         = '0;
        B         = '0;
        kill      = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", Out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge Clock);

        // Directed arithmetic
        run_op("mul_neg",  3'd0, 32'hFFFF_FFFE, 32'h0000_0003, LAT_NORMAL, 32'hFFFF_FFFA);
        run_op("mulhu",    3'd3, 32'hFFFF_FFFE, 32'h0000_0003, LAT_NORMAL, 32'h0000_0002);
        run_op("div_neg",  3'd4, 32'hFFFF_FFF9, 32'h0000_0002, LAT_NORMAL, 32'hFFFF_FFFD);
        run_op("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'h0000_0002, LAT_NORMAL, 32'hFFFF_FFFF);
        run_op("divu",     3'd5, 32'hFFFF_FFF9, 32'h0000_0002, LAT_NORMAL, 32'h7FFF_FFFC);

        // Special cases bypass the iteration
        run_op("divu_zero", 3'd5, 32'h1234_5678, 32'h0, LAT_SPECIAL, 32'hFFFF_FFFF);
        run_op("remu_zero", 3'd7, 32'h1234_5678, 32'h0, LAT_SPECIAL, 32'h1234_5678);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SPECIAL, 32'h8000_0000);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SPECIAL, 32'h0000_0000);

        // Backpressure: result held, new request ignored while in DONE
        issue("bp", 3'd0, 32'd7, 32'd6);
        wait_result("bp", LAT_NORMAL, 32'd42);
        in_valid = 1'b1;
        funct    = 3'd1;
        A        = 32'h8000_0000;
        B        = 32'h0000_0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check("bp_hold_out", Out, 32'd42);
            check("bp_hold_state", 32'({out_valid, in_ready, busy}), 32'b101);
        end
        out_ready = 1'b1;
        @(negedge Clock);
        out_ready = 1'b0;
        check("bp_release", 32'({out_valid, in_ready}), 32'b01);
        @(negedge Clock);
        in_valid = 1'b0;
        check("bp_next_accept", 32'(busy), 32'd1);
        wait_result("bp_next", LAT_NORMAL, model(3'd1, 32'h8000_0000, 32'h0000_0002));
        consume("bp_next");

        // kill during CALC iteration 10
        issue("kill", 3'd5, 32'hDEAD_BEEF, 32'd3);
        repeat (10) @(negedge Clock);
        kill = 1'b1;
        @(negedge Clock);
        kill = 1'b0;
        check("kill_idle", 32'({busy, in_ready, out_valid}), 32'b010);
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (out_valid) rose = 1'b1;
        end
        check("kill_no_valid", 32'(rose), 32'd0);

        // kill in IDLE blocks an accept on the same edge
        in_valid = 1'b1;
        kill     = 1'b1;
        funct    = 3'd0;
        @(negedge Clock);
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill_idle_block", 32'(busy), 32'd0);

        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, LAT_NORMAL, 32'h4000_0000);

        // kill in DONE discards a pending result
        issue("kill_done", 3'd0, 32'd5, 32'd5);
        wait_result("kill_done", LAT_NORMAL, 32'd25);
        kill      = 1'b1;
        out_ready = 1'b1;
        @(negedge Clock);
        kill      = 1'b0;
        out_ready = 1'b0;
        check("kill_done_idle", 32'({busy, out_valid}), 32'b00);

        // Asynchronous reset mid-CALC, between edges
        issue("arst", 3'd2, 32'hF000_0001, 32'h1234_5678);
        repeat (5) @(negedge Clock);
        held = Out;
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", 32'({out_valid, busy, in_ready}), 32'b001);
        check("arst_out", Out, 32'd0);
        @(negedge Clock);
        reset_n = 1'b1;
        @(negedge Clock);
        check("arst_after", 32'({out_valid, busy, in_ready}), 32'b001);
        if (held == 32'd0) $display("note: output word was already zero before reset");

        // Randomized operations against the model
        for (int n = 0; n < 25; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d_f%0d", n, rf), rf, ra, rb, exp_latency(rf, ra, rb), model(rf, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same operand pair (A, B) after the forwarding and immediate muxes.
- Its result feeds the writeback mux in parallel with the ALU output. The hazard unit stalls the pipeline while the unit is busy.
- It handles the eight OPC_ARI_RTYPE instructions with funct7 = 0000001, selected by funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the parameter is for bench sizing only.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- Clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept; equals (state==IDLE)
- funct  input  3  RV32M funct3 (000 MUL … 111 REMU); sampled only on accept
- A  input  32  rs1 operand; sampled only on accept
- B  input  32  rs2 operand; sampled only on accept
- kill  input  1  pipeline flush; abandons any operation
- out_valid  output  1  result available
- out_ready  input  1  writeback consumes result
- Out  output  32  result
- busy  output  1  state != IDLE; drives the stall logic

Behaviour:
- Clock and reset: one clock, Clock. Reset reset_n is asynchronous, active-low. While reset_n=0: state=IDLE, out_valid=0, Out=0, busy=0, in_ready=1, and the counter and datapath registers are cleared. Deasserting reset mid-operation leaves the unit in IDLE; any in-flight operation is lost.
- Accept: in_valid && in_ready at a rising edge latches funct, A and B.
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC on a normal accept. IDLE → FIX on a special-case accept (see below).
- CALC:
  - Runs exactly 32 edges; the counter counts 0..31 and the transition to FIX happens on the edge where counter==31.
  - Multiply: radix-2 shift-add on operand magnitudes into a 64-bit product.
  - Divide: restoring division on magnitudes producing a 32-bit quotient and remainder.
- FIX (1 edge): applies sign correction and selects the output word, then → DONE.
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - DIV/REM: both operands signed.
  - The product is negated when the operand signs differ. The quotient is negated when the operand signs differ. The remainder takes the sign of A.
- Special cases, detected on accept, bypass CALC:
  - Divide by zero (B==0), DIV/DIVU: Out=32'hFFFF_FFFF.
  - Divide by zero (B==0), REM/REMU: Out=A.
  - Signed overflow (DIV/REM with A=32'h8000_0000, B=32'hFFFF_FFFF): DIV gives 32'h8000_0000, REM gives 0.
- DONE:
  - out_valid=1 and Out is held stable while out_ready=0.
  - out_valid && out_ready at an edge → IDLE, out_valid=0.
  - A new request is accepted no earlier than the edge after the result is consumed; in_ready=0 in DONE.
- Latency, for an accept at edge k:
  - Normal operation: out_valid is high after edge k+34.
  - Special case: out_valid is high after edge k+2.
- Back-to-back: after consume at edge m, the next accept can occur at edge m+1.
- kill: on an edge with kill=1 in CALC, FIX or DONE → IDLE, out_valid=0, and any pending result is discarded. kill has priority over out_ready. kill in IDLE blocks an accept on the same edge.
- Out is don't-care when out_valid=0; the implementation holds the last value.

Decomposition:
- Shared package/header (an extension of Opcode.vh):
  - FNC_MUL … FNC_REMU funct3 constants.
  - FNC7_MULDIV = 7'b0000001.
  - State encodings MD_IDLE, MD_CALC, MD_FIX, MD_DONE.
- ALUdec gains an is_muldiv output that qualifies in_valid.
- Sub-module muldiv_core: the combinational single-iteration step (shift-add or restoring-subtract on one bit). The FSM, counter and sign-fix logic stay in muldiv_unit.

Test Plan:
- MUL, A=32'hFFFF_FFFE (-2), B=32'h0000_0003 → Out=32'hFFFF_FFFA, out_valid 34 edges after accept; MULHU with the same operands → 32'h0000_0002.
- DIV, A=32'hFFFF_FFF9 (-7), B=2 → 32'hFFFF_FFFD; REM with the same operands → 32'hFFFF_FFFF; DIVU with the same operands → 32'h7FFF_FFFC.
- Divide by zero: DIVU with A=32'h1234_5678, B=0 → 32'hFFFF_FFFF after 2 edges; REMU with the same operands → 32'h1234_5678. Overflow case: DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000; REM with the same operands → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → Out stable, in_ready=0, and a new in_valid is ignored; raise out_ready → next-cycle accept succeeds.
- Assert kill at CALC iteration 10 → IDLE next edge, out_valid never rises, and a subsequent MULH with A=32'h8000_0000, B=32'h8000_0000 → 32'h4000_0000.
- Pull reset_n low mid-CALC between clock edges → outputs reset immediately (asynchronously); then run 25 random funct/A/B operations compared against a behavioural model.
